// File: rtl/rr_stream_mux_nx1.sv
// N-to-1 valid/ready stream merger with round-robin arbitration and one registered output stage.
// out_sel carries the index of the source that produced each beat.
module rr_stream_mux_nx1 #(
  parameter int N         = 4,
  parameter int DATA_W    = 8,
  parameter int SEL_WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          in_valid,
  input  logic [N*DATA_W-1:0]   in_data,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [SEL_WIDTH-1:0]  out_sel,
  input  logic                  out_ready
);

  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic [SEL_WIDTH-1:0] r_out_sel;
  logic [SEL_WIDTH-1:0] r_rr_ptr;

  logic [DATA_W-1:0]    w_slice [N];
  logic [N-1:0]         w_grant;
  logic                 w_any;
  logic [SEL_WIDTH-1:0] w_gnt_idx;
  logic [SEL_WIDTH-1:0] w_cand;
  logic [SEL_WIDTH-1:0] w_ptr_next;
  logic                 w_load;
  logic                 w_take;

  // Modulo-N increment that also works when N is not a power of two.
  function automatic logic [SEL_WIDTH-1:0] wrap_add(input logic [SEL_WIDTH-1:0] base,
                                                    input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return SEL_WIDTH'(sum);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      assign w_slice[gi] = in_data[gi*DATA_W +: DATA_W];
      assign w_grant[gi] = w_any && (w_gnt_idx == SEL_WIDTH'(gi));
    end
  endgenerate

  // Circular search starting at the pointer; the first requester encountered wins.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = wrap_add(r_rr_ptr, k);
      if (!w_any && in_valid[w_cand]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_load     = !r_out_valid || out_ready;
  assign w_take     = w_load && w_any;
  assign w_ptr_next = wrap_add(w_gnt_idx, 1);

  // Gated by rst_n so no source sees a handshake while reset is held.
  assign in_ready = (rst_n && w_load) ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_slice[w_gnt_idx];
      r_out_sel   <= w_gnt_idx;
      r_rr_ptr    <= w_ptr_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_stream_mux_nx1.sv
// Bench for rr_stream_mux_nx1: directed scenarios plus a random soak on an N=4 and an N=3 instance,
// both compared every cycle against a transaction-level round-robin model.
module tb_rr_stream_mux_nx1;

  localparam int NA = 4;
  localparam int NB = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NA-1:0]    a_in_valid, a_in_ready;
  logic [NA*DW-1:0] a_in_data;
  logic             a_out_valid, a_out_ready;
  logic [DW-1:0]    a_out_data;
  logic [1:0]       a_out_sel;

  logic [NB-1:0]    b_in_valid, b_in_ready;
  logic [NB*DW-1:0] b_in_data;
  logic             b_out_valid, b_out_ready;
  logic [DW-1:0]    b_out_data;
  logic [1:0]       b_out_sel;

  rr_stream_mux_nx1 #(.N(NA), .DATA_W(DW)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_sel(a_out_sel),
    .out_ready(a_out_ready)
  );

  rr_stream_mux_nx1 #(.N(NB), .DATA_W(DW)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_sel(b_out_sel),
    .out_ready(b_out_ready)
  );

  int vectors    = 0;
  int miscompares = 0;

  int         n_src[2] = '{NA, NB};
  bit         src_v[2][4];
  logic [7:0] src_d[2][4];
  bit         o_rdy[2];
  bit         m_valid[2];
  logic [7:0] m_data[2];
  int         m_sel[2];
  int         m_ptr[2];
  int         waits[2][4];
  logic [3:0] last_ir[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < NA; i++) begin
      a_in_valid[i]          = src_v[0][i];
      a_in_data[i*DW +: DW]  = src_d[0][i];
    end
    for (int i = 0; i < NB; i++) begin
      b_in_valid[i]          = src_v[1][i];
      b_in_data[i*DW +: DW]  = src_d[1][i];
    end
    a_out_ready = o_rdy[0];
    b_out_ready = o_rdy[1];
  endtask

  task automatic get_dut(input int inst, output logic ov, output logic [7:0] od,
                         output logic [1:0] os, output logic [3:0] ir);
    if (inst == 0) begin
      ov = a_out_valid; od = a_out_data; os = a_out_sel; ir = a_in_ready;
    end else begin
      ov = b_out_valid; od = b_out_data; os = b_out_sel; ir = {1'b0, b_in_ready};
    end
  endtask

  // Next winner: first valid source at or after the pointer, going around the ring.
  function automatic int winner(input int inst);
    for (int k = 0; k < n_src[inst]; k++) begin
      int s = (m_ptr[inst] + k) % n_src[inst];
      if (src_v[inst][s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int inst = 0; inst < 2; inst++) begin
      m_valid[inst] = 1'b0;
      m_data[inst]  = 8'h00;
      m_sel[inst]   = 0;
      m_ptr[inst]   = 0;
      for (int i = 0; i < 4; i++) begin
        waits[inst][i] = 0;
        src_v[inst][i] = 1'b0;
      end
    end
  endtask

  task automatic fill(input int inst);
    for (int i = 0; i < n_src[inst]; i++)
      if (!src_v[inst][i]) begin
        src_v[inst][i] = 1'b1;
        src_d[inst][i] = 8'($urandom);
      end
  endtask

  // One clock: check in_ready mid-cycle, advance the model, check registered outputs after the edge.
  task automatic cycle();
    logic       ov;
    logic [7:0] od;
    logic [1:0] os;
    logic [3:0] ir, exp_ir;
    int         w;
    bit         load;
    string      p;
    apply_inputs();
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      p = (inst == 0) ? "a" : "b";
      get_dut(inst, ov, od, os, ir);
      last_ir[inst] = ir;
      w      = winner(inst);
      load   = !m_valid[inst] || o_rdy[inst];
      exp_ir = (load && w >= 0) ? 4'(1 << w) : 4'b0000;
      chk({p, "_in_ready"}, 32'(ir), 32'(exp_ir));
      if (ir != 4'b0000) begin
        for (int j = 0; j < n_src[inst]; j++) begin
          if (ir[j]) waits[inst][j] = 0;
          else if (src_v[inst][j]) begin
            waits[inst][j]++;
            chk({p, "_starve_le_n1"}, 32'(waits[inst][j] <= n_src[inst] - 1), 32'd1);
          end
        end
      end
      if (load && w >= 0) begin
        m_valid[inst]  = 1'b1;
        m_data[inst]   = src_d[inst][w];
        m_sel[inst]    = w;
        m_ptr[inst]    = (w + 1) % n_src[inst];
        src_v[inst][w] = 1'b0;
      end else if (o_rdy[inst]) begin
        m_valid[inst] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      p = (inst == 0) ? "a" : "b";
      get_dut(inst, ov, od, os, ir);
      chk({p, "_out_valid"}, 32'(ov), 32'(m_valid[inst]));
      chk({p, "_out_data"},  32'(od), 32'(m_data[inst]));
      chk({p, "_out_sel"},   32'(os), 32'(m_sel[inst]));
    end
  endtask

  initial begin
    logic       ov;
    logic [7:0] od;
    logic [1:0] os;
    logic [3:0] ir;

    rst_n = 1'b0;
    model_reset();
    o_rdy = '{1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      src_d[0][i] = 8'h00;
      src_d[1][i] = 8'h00;
    end
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      get_dut(inst, ov, od, os, ir);
      chk("reset_valid", 32'(ov), 32'd0);
      chk("reset_data",  32'(od), 32'd0);
      chk("reset_sel",   32'(os), 32'd0);
      chk("reset_ready", 32'(ir), 32'd0);
    end
    rst_n = 1'b1;

    // Load a beat into each instance, then pull reset mid-cycle while it is held.
    src_v[0][0] = 1'b1; src_d[0][0] = 8'h3C;
    src_v[1][2] = 1'b1; src_d[1][2] = 8'hC3;
    cycle();
    src_v[0][1] = 1'b1; src_d[0][1] = 8'h11;
    o_rdy = '{1'b1, 1'b1};
    apply_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      get_dut(inst, ov, od, os, ir);
      chk("async_rst_valid", 32'(ov), 32'd0);
      chk("async_rst_data",  32'(od), 32'd0);
      chk("async_rst_sel",   32'(os), 32'd0);
      chk("async_rst_ready", 32'(ir), 32'd0);
    end
    model_reset();
    apply_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("idle_valid", 32'(a_out_valid), 32'd0);
    end

    // Single source 2 on the N=4 instance.
    src_v[0][2] = 1'b1; src_d[0][2] = 8'hA5;
    cycle();
    chk("single_ready", 32'(last_ir[0]), 32'h4);
    chk("single_data",  32'(a_out_data), 32'hA5);
    chk("single_sel",   32'(a_out_sel),  32'd2);
    fill(0);
    cycle();
    chk("ptr_after_single", 32'(last_ir[0]), 32'h8);

    // All valid, full throughput: 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      fill(0);
      cycle();
      chk("rr_sel",   32'(a_out_sel),   32'(c % 4));
      chk("rr_valid", 32'(a_out_valid), 32'd1);
    end

    // Backpressure while holding the beat from source 1.
    fill(0); cycle();
    fill(0); cycle();
    chk("bp_pre_sel", 32'(a_out_sel), 32'd1);
    o_rdy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      fill(0);
      cycle();
      chk("bp_ready", 32'(last_ir[0]), 32'd0);
      chk("bp_sel",   32'(a_out_sel),  32'd1);
      chk("bp_valid", 32'(a_out_valid), 32'd1);
    end
    o_rdy[0] = 1'b1;
    cycle();
    chk("bp_release_sel", 32'(a_out_sel), 32'd2);

    // Wrap and skip on the N=3 instance.
    for (int i = 0; i < 4; i++) src_v[0][i] = 1'b0;
    src_v[1][1] = 1'b1; src_d[1][1] = 8'h21;
    cycle();
    chk("n3_first_sel", 32'(b_out_sel), 32'd1);
    src_v[1][0] = 1'b1; src_d[1][0] = 8'h30;
    src_v[1][1] = 1'b1; src_d[1][1] = 8'h31;
    cycle();
    chk("n3_wrap_ready", 32'(last_ir[1]), 32'h1);
    chk("n3_wrap_sel",   32'(b_out_sel),  32'd0);
    cycle();
    chk("n3_next_sel",   32'(b_out_sel),  32'd1);
    chk("n3_next_data",  32'(b_out_data), 32'h31);

    // Random soak on both instances.
    for (int c = 0; c < 10000; c++) begin
      for (int inst = 0; inst < 2; inst++) begin
        for (int i = 0; i < n_src[inst]; i++)
          if (!src_v[inst][i] && $urandom_range(0, 1) == 1) begin
            src_v[inst][i] = 1'b1;
            src_d[inst][i] = 8'($urandom);
          end
        o_rdy[inst] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
